// File: rtl/keycode_move_queue_if.sv
// Keycode / move handshake bundle between the SoC-side keycode source,
// the animator and keycode_move_queue.
// The slave modport is the queue itself; master is the SoC/animator side.
interface keycode_move_queue_if #(
  parameter int DEPTH = 8
);
  logic [7:0]             keycode;
  logic                   move_ready;
  logic                   move_valid;
  logic [3:0]             move;
  logic [$clog2(DEPTH):0] queue_count;
  logic                   overflow;
  logic                   busy;

  modport master (
    output keycode, move_ready,
    input  move_valid, move, queue_count, overflow, busy
  );

  modport slave (
    input  keycode, move_ready,
    output move_valid, move, queue_count, overflow, busy
  );
endinterface

// File: rtl/keycode_move_queue.sv
// keycode_move_queue: turns HID keycode press edges into 4-bit cube moves
// {prime, face} and buffers them in a DEPTH-entry FIFO popped by the
// animator with a valid/ready handshake. Esc flushes the queue.
// Optional feature macro: SCRAMBLE_EN -- a space press starts an
// LFSR-driven scramble of SCRAMBLE_LEN moves (busy is high meanwhile).
// Without the macro there is no FSM/LFSR and busy is tied low.
module keycode_move_queue #(
  parameter int          DEPTH        = 8,
  parameter int          SCRAMBLE_LEN = 20,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset_n,
  keycode_move_queue_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [7:0]    KC_ESC     = 8'h29;

  // Map a keycode to {is_move, prime, face}; non-move codes give 0.
  function automatic logic [4:0] decode_move(input logic [7:0] kc);
    logic [4:0] res;
    res = 5'b0_0_000;
    case (kc)
      8'h18:   res = 5'b1_0_000; // U
      8'h07:   res = 5'b1_0_001; // D
      8'h0F:   res = 5'b1_0_010; // L
      8'h15:   res = 5'b1_0_011; // R
      8'h09:   res = 5'b1_0_100; // F
      8'h05:   res = 5'b1_0_101; // B
      8'h1E:   res = 5'b1_1_000; // U'
      8'h1F:   res = 5'b1_1_001; // D'
      8'h20:   res = 5'b1_1_010; // L'
      8'h21:   res = 5'b1_1_011; // R'
      8'h22:   res = 5'b1_1_100; // F'
      8'h23:   res = 5'b1_1_101; // B'
      default: res = 5'b0_0_000;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Keycode capture and press-edge detection
  // ---------------------------------------------------------------------
  logic [7:0] kc_q_r;
  logic [7:0] kc_prev_r;
  logic       press_s;
  logic [4:0] dec_s;
  logic       flush_s;
  logic       key_move_s;

  // Register the keycode and keep the previous sample for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_q_r    <= 8'h00;
      kc_prev_r <= 8'h00;
    end else begin
      kc_q_r    <= bus.keycode;
      kc_prev_r <= kc_q_r;
    end
  end

  // A press is any change to a nonzero code, so key rollover also counts.
  assign press_s    = (kc_q_r != kc_prev_r) && (kc_q_r != 8'h00);
  assign dec_s      = decode_move(kc_q_r);
  assign flush_s    = press_s && (kc_q_r == KC_ESC);
  assign key_move_s = press_s && dec_s[4];

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic [3:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic          full_s;
  logic          valid_s;
  logic          pop_s;
  logic          can_push_s;
  logic          scr_req_s;
  logic [3:0]    scr_move_s;
  logic          key_push_req_s;
  logic          push_s;
  logic [3:0]    push_data_s;
  logic          drop_s;

  assign full_s     = (count_r == FULL_COUNT);
  assign valid_s    = (count_r != {CW{1'b0}});
  assign pop_s      = valid_s && bus.move_ready;
  // A simultaneous pop frees the slot a full FIFO needs for the push.
  assign can_push_s = !full_s || pop_s;

  // Keyboard moves are locked out while a scramble owns the FIFO input.
  assign key_push_req_s = key_move_s && !scr_req_s;
  assign push_data_s    = scr_req_s ? scr_move_s : dec_s[3:0];
  assign push_s         = (key_push_req_s || scr_req_s) && can_push_s && !flush_s;
  // Only keyboard moves are ever dropped; a scramble stalls instead.
  assign drop_s         = key_push_req_s && !can_push_s;

  // FIFO storage, pointers, occupancy and sticky overflow; flush wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 4'h0;
      end
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else if (flush_s) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.move_valid  = valid_s;
  assign bus.move        = mem_r[rd_ptr_r];
  assign bus.queue_count = count_r;
  assign bus.overflow    = overflow_r;

`ifdef SCRAMBLE_EN
  // ---------------------------------------------------------------------
  // Scramble generator
  // ---------------------------------------------------------------------
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] SCR_LAST = 8'(SCRAMBLE_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_SCRAMBLE = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] lfsr_r;
  logic [7:0]  scr_cnt_r;
  logic [2:0]  prev_face_r;
  logic [2:0]  base_face_s;
  logic [2:0]  face_s;
  logic        space_press_s;
  logic        scr_push_s;

  assign space_press_s = press_s && (kc_q_r == KC_SPACE);
  assign scr_req_s     = (state_r == ST_SCRAMBLE);
  assign scr_push_s    = scr_req_s && can_push_s && !flush_s;
  assign scr_move_s    = {lfsr_r[3], face_s};
  assign bus.busy      = (state_r == ST_SCRAMBLE);

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  // Fold the 3 LFSR bits onto faces 0..5 and avoid repeating the last face.
  always_comb begin
    base_face_s = lfsr_r[2:0];
    face_s      = lfsr_r[2:0];
    case (lfsr_r[2:0])
      3'd6:    base_face_s = 3'd0;
      3'd7:    base_face_s = 3'd1;
      default: base_face_s = lfsr_r[2:0];
    endcase
    if (base_face_s == prev_face_r) begin
      if (base_face_s == 3'd5) begin
        face_s = 3'd0;
      end else begin
        face_s = base_face_s + 3'd1;
      end
    end else begin
      face_s = base_face_s;
    end
  end

  // Scramble state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: space starts a scramble, Esc or the last push ends it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (space_press_s) begin
          state_s = ST_SCRAMBLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCRAMBLE: begin
        if (flush_s) begin
          state_s = ST_IDLE;
        end else if (scr_push_s && (scr_cnt_r == SCR_LAST)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SCRAMBLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Count scramble pushes and remember the last face; 7 means "none yet".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scr_cnt_r   <= 8'd0;
      prev_face_r <= 3'd7;
    end else if (state_r == ST_IDLE) begin
      scr_cnt_r   <= 8'd0;
      prev_face_r <= 3'd7;
    end else if (scr_push_s) begin
      scr_cnt_r   <= scr_cnt_r + 8'd1;
      prev_face_r <= face_s;
    end
  end
`else
  // Scramble support not built: no generator, busy held low.
  logic unused_cfg_s;

  assign scr_req_s    = 1'b0;
  assign scr_move_s   = 4'h0;
  assign bus.busy     = 1'b0;
  assign unused_cfg_s = ^{LFSR_SEED, 8'(SCRAMBLE_LEN)};
`endif

endmodule
